data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_array.sv | 40 ++++
 rtl/data_memory.sv | 143 ++++++++++++++
 tb/tb_data_memory.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg -- shared types and constants for the data_memory block.
//   state_t                : FSM state encoding (IDLE, BUSY, DONE)
//   BLOCK_W                : width of one memory block in bits
//   BLOCK_ADDR_W           : width of the incoming block address
//   DEFAULT_ACCESS_LATENCY : default request-accept-to-completion cycle count
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned BLOCK_W                = 128;
  localparam int unsigned BLOCK_ADDR_W           = 28;
  localparam int unsigned DEFAULT_ACCESS_LATENCY = 5;

endpackage

// File: rtl/dmem_array.sv
// dmem_array -- single-port block store, synchronous write and synchronous
// registered read. The read register clears on reset; the storage does not.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset, clears rdata only
//   we    : write enable, stores wdata at addr
//   re    : read enable, loads rdata from addr
//   addr  : block index
//   wdata : block to store
//   rdata : registered block, held until the next read
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [BLOCK_W-1:0]    wdata,
  output logic [BLOCK_W-1:0]    rdata
);

  logic [BLOCK_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_memory.sv
// data_memory -- block-granular backing memory for a cache controller with a
// fixed, parameterised access latency and a BUSYWAIT handshake.
//   CLK        : clock, rising edge
//   RESET      : synchronous active-low reset (state, counter, READ_DATA)
//   MEM_READ   : block read request
//   MEM_WRITE  : block write request (wins when both requests are high)
//   BLOCK_ADDR : block address, low DEPTH_LOG2 bits index the array
//   WRITE_DATA : block to store on a write
//   READ_DATA  : registered block from the last completed read
//   BUSYWAIT   : high while a request is being served
//   RD_COUNT   : completed reads  (only with DATA_MEMORY_PERF_CNT_EN)
//   WR_COUNT   : completed writes (only with DATA_MEMORY_PERF_CNT_EN)
// Optional feature macro: DATA_MEMORY_PERF_CNT_EN adds the access counters.
module data_memory
  import dmem_pkg::*;
#(
  parameter int unsigned ACCESS_LATENCY = DEFAULT_ACCESS_LATENCY,
  parameter int unsigned DEPTH_LOG2     = 8
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    MEM_READ,
  input  logic                    MEM_WRITE,
  input  logic [BLOCK_ADDR_W-1:0] BLOCK_ADDR,
  input  logic [BLOCK_W-1:0]      WRITE_DATA,
  output logic [BLOCK_W-1:0]      READ_DATA,
  output logic                    BUSYWAIT
`ifdef DATA_MEMORY_PERF_CNT_EN
  ,
  output logic [31:0]             RD_COUNT,
  output logic [31:0]             WR_COUNT
`endif
);

  localparam logic [7:0] CNT_LOAD = 8'(ACCESS_LATENCY - 1);

  state_t                state;
  state_t                state_nxt;
  logic [7:0]            cnt;
  logic                  req;
  logic                  accept;
  logic                  finish;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [BLOCK_W-1:0]    wdata_q;
  logic                  wr_q;

  assign req = MEM_READ | MEM_WRITE;

  generate
    if (DEPTH_LOG2 < BLOCK_ADDR_W) begin : g_addr_sink
      // Upper address bits are deliberately ignored.
      logic unused_addr_hi;
      assign unused_addr_hi = ^BLOCK_ADDR[BLOCK_ADDR_W-1:DEPTH_LOG2];
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    BUSYWAIT  = 1'b0;
    accept    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        // Combinational so the controller stalls in the request cycle itself.
        BUSYWAIT = req;
        if (req) begin
          accept    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        BUSYWAIT = 1'b1;
        if (cnt == 8'd0) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // Reset forces IDLE behaviour and suppresses any pending array access.
    if (!RESET) begin
      BUSYWAIT = req;
      accept   = 1'b0;
      finish   = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt <= CNT_LOAD;
      end else if ((state == BUSY) && (cnt != 8'd0)) begin
        cnt <= cnt - 8'd1;
      end
    end
  end

  // Request capture; contents are only consumed while BUSY.
  always_ff @(posedge CLK) begin
    if (accept) begin
      idx_q   <= BLOCK_ADDR[DEPTH_LOG2-1:0];
      wdata_q <= WRITE_DATA;
      wr_q    <= MEM_WRITE;
    end
  end

  dmem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk  (CLK),
    .rst_n(RESET),
    .we   (finish & wr_q),
    .re   (finish & ~wr_q),
    .addr (idx_q),
    .wdata(wdata_q),
    .rdata(READ_DATA)
  );

`ifdef DATA_MEMORY_PERF_CNT_EN
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      RD_COUNT <= 32'd0;
      WR_COUNT <= 32'd0;
    end else if (finish) begin
      if (wr_q) begin
        WR_COUNT <= WR_COUNT + 32'd1;
      end else begin
        RD_COUNT <= RD_COUNT + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory -- directed bench for data_memory: one instance at the
// default latency (5) and one at latency 1, sharing clock and reset.
module tb_data_memory;

  logic         CLK = 1'b0;
  logic         RESET = 1'b0;

  logic         r5 = 1'b0, w5 = 1'b0;
  logic [27:0]  a5 = '0;
  logic [127:0] d5 = '0;
  logic [127:0] q5;
  logic         busy5;

  logic         r1 = 1'b0, w1 = 1'b0;
  logic [27:0]  a1 = '0;
  logic [127:0] d1 = '0;
  logic [127:0] q1;
  logic         busy1;

`ifdef DATA_MEMORY_PERF_CNT_EN
  logic [31:0] rdc5, wrc5, rdc1, wrc1;
`endif

  int checks = 0;
  int failures = 0;

  localparam logic [127:0] VAL_A = 128'hDEADBEEF_00000001_CAFEF00D_12345678;
  localparam logic [127:0] VAL_B = 128'h0BADF00D_11112222_33334444_55556666;
  localparam logic [127:0] VAL_D = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
  localparam logic [127:0] VAL_E = 128'hFFFFFFFF_EEEEEEEE_DDDDDDDD_CCCCCCCC;
  localparam logic [127:0] VAL_F = 128'h01234567_89ABCDEF_FEDCBA98_76543210;

  always #5 CLK = ~CLK;

  data_memory #(.ACCESS_LATENCY(5), .DEPTH_LOG2(8)) dut (
    .CLK(CLK), .RESET(RESET), .MEM_READ(r5), .MEM_WRITE(w5),
    .BLOCK_ADDR(a5), .WRITE_DATA(d5), .READ_DATA(q5), .BUSYWAIT(busy5)
`ifdef DATA_MEMORY_PERF_CNT_EN
    , .RD_COUNT(rdc5), .WR_COUNT(wrc5)
`endif
  );

  data_memory #(.ACCESS_LATENCY(1), .DEPTH_LOG2(8)) dut1 (
    .CLK(CLK), .RESET(RESET), .MEM_READ(r1), .MEM_WRITE(w1),
    .BLOCK_ADDR(a1), .WRITE_DATA(d1), .READ_DATA(q1), .BUSYWAIT(busy1)
`ifdef DATA_MEMORY_PERF_CNT_EN
    , .RD_COUNT(rdc1), .WR_COUNT(wrc1)
`endif
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input bit sel, input bit rd, input bit wr,
                       input logic [27:0] a, input logic [127:0] d);
    if (sel) begin
      r1 = rd; w1 = wr; a1 = a; d1 = d;
    end else begin
      r5 = rd; w5 = wr; a5 = a; d5 = d;
    end
  endtask

  function automatic logic busy_of(input bit sel);
    return sel ? busy1 : busy5;
  endfunction

  // Raises a request, checks same-cycle BUSYWAIT, counts edges until BUSYWAIT
  // falls. Without hold the request drops after the accept edge and one more
  // edge is taken so the DUT is back in IDLE on return; with hold the request
  // stays up and the task returns in the DONE cycle.
  task automatic run_req(input string tag, input bit sel, input bit rd, input bit wr,
                         input logic [27:0] a, input logic [127:0] d,
                         input bit hold, input int exp_edges);
    int n;
    drive(sel, rd, wr, a, d);
    #1;
    check({tag, "_busy_same_cycle"}, 128'(busy_of(sel)), 128'd1);
    n = 0;
    do begin
      step();
      n++;
      if (!hold) drive(sel, 1'b0, 1'b0, a, d);
    end while (busy_of(sel) && n < 300);
    check({tag, "_edges_to_ready"}, 128'(n), 128'(exp_edges));
    if (!hold) step();
  endtask

  initial begin
    // Reset: outputs cleared, BUSYWAIT follows the IDLE rule.
    RESET = 1'b0;
    repeat (3) step();
    check("rst_busy", 128'(busy5), 128'd0);
    check("rst_rdata", q5, 128'd0);
    check("rst_rdata_l1", q1, 128'd0);
    r5 = 1'b1;
    #1;
    check("rst_busy_follows_req", 128'(busy5), 128'd1);
    r5 = 1'b0;
    step();
    RESET = 1'b1;
    step();

    // Write 0x5, then read it back.
    run_req("wr5", 1'b0, 1'b0, 1'b1, 28'h5, VAL_A, 1'b0, 6);
    check("wr5_rdata_untouched", q5, 128'd0);
    run_req("rd5", 1'b0, 1'b1, 1'b0, 28'h5, '0, 1'b0, 6);
    check("rd5_rdata", q5, VAL_A);

    // Read held through DONE, then dropped: exactly one access.
    run_req("rdhold", 1'b0, 1'b1, 1'b0, 28'h5, '0, 1'b1, 6);
    drive(1'b0, 1'b0, 1'b0, 28'h5, '0);
    step();
    check("rdhold_idle", 128'(busy5), 128'd0);
    step();
    check("rdhold_no_reaccept", 128'(busy5), 128'd0);
    check("rdhold_rdata", q5, VAL_A);
`ifdef DATA_MEMORY_PERF_CNT_EN
    check("rdhold_rd_count", 128'(rdc5), 128'd2);
    check("rdhold_wr_count", 128'(wrc5), 128'd1);
`endif

    // Write then read back-to-back: no gap after DONE.
    run_req("wrb2b", 1'b0, 1'b0, 1'b1, 28'h7, VAL_B, 1'b1, 6);
    drive(1'b0, 1'b1, 1'b0, 28'h7, '0);
    step();
    check("b2b_no_gap", 128'(busy5), 128'd1);
    run_req("rdb2b", 1'b0, 1'b1, 1'b0, 28'h7, '0, 1'b0, 6);
    check("b2b_rdata", q5, VAL_B);

    // Both requests high: treated as a write.
    run_req("both", 1'b0, 1'b1, 1'b1, 28'h10, VAL_D, 1'b0, 6);
    check("both_rdata_unchanged", q5, VAL_B);
    run_req("rd10", 1'b0, 1'b1, 1'b0, 28'h10, '0, 1'b0, 6);
    check("rd10_rdata", q5, VAL_D);

    // Reset during the third BUSY cycle of a write to 0x7.
    drive(1'b0, 1'b0, 1'b1, 28'h7, VAL_E);
    step();
    drive(1'b0, 1'b0, 1'b0, 28'h7, VAL_E);
    step();
    step();
    check("abort_busy_mid", 128'(busy5), 128'd1);
    RESET = 1'b0;
    #1;
    check("abort_busy_in_reset", 128'(busy5), 128'd0);
    step();
    check("abort_busy_after", 128'(busy5), 128'd0);
    check("abort_rdata_cleared", q5, 128'd0);
    RESET = 1'b1;
    run_req("rd7", 1'b0, 1'b1, 1'b0, 28'h7, '0, 1'b0, 6);
    check("abort_retained", q5, VAL_B);
`ifdef DATA_MEMORY_PERF_CNT_EN
    check("final_rd_count", 128'(rdc5), 128'd1);
    check("final_wr_count", 128'(wrc5), 128'd0);
`endif

    // Latency 1: upper address bits ignored, ready after 2 edges.
    run_req("l1_wr", 1'b1, 1'b0, 1'b1, 28'h1000003, VAL_F, 1'b0, 2);
    run_req("l1_rd", 1'b1, 1'b1, 1'b0, 28'h0000003, '0, 1'b0, 2);
    check("l1_rdata", q1, VAL_F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
